// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO pop port and the valid/ready stream side of fifo_stream_reader.
// The master modport is the reader; the slave modport is the FIFO plus the stream consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0]  words_out;
    logic                  busy;

    modport master (
        input  fifo_data,
        input  fifo_empty,
        input  flush,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output words_out,
        output busy
    );

    modport slave (
        output fifo_data,
        output fifo_empty,
        output flush,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  words_out,
        input  busy
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a 1-cycle-latency synchronous FIFO and presents the
// words as a valid/ready stream through a 3-entry circular skid buffer.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_stream_reader_if.master bus
);
    logic [DATA_WIDTH-1:0] skid_q [3];
    logic [1:0]            cnt;
    logic [1:0]            head;
    logic [1:0]            tail;
    logic                  inflight;
    logic [CNT_WIDTH-1:0]  words_q;

    logic                  rd_en;
    logic                  handshake;
    logic [2:0]            occupancy;
    logic [2:0]            cnt_nxt;

    function automatic logic [1:0] wrap_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pops are reserved against words held plus the one possibly in flight,
    // so the buffer can never overflow and m_ready never reaches fifo_rd_en.
    assign occupancy = {1'b0, cnt} + {2'b00, inflight};
    assign rd_en     = !rst && !bus.flush && !bus.fifo_empty && (occupancy < 3'd3);
    assign handshake = (cnt != 2'd0) && bus.m_ready;
    assign cnt_nxt   = occupancy - {2'b00, handshake};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            head     <= '0;
            tail     <= '0;
            inflight <= 1'b0;
            words_q  <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            if (handshake) begin
                words_q <= words_q + 1'b1;
            end
            if (bus.flush) begin
                // The word from a pop issued last cycle is simply never captured.
                cnt      <= '0;
                head     <= '0;
                tail     <= '0;
                inflight <= 1'b0;
            end else begin
                inflight <= rd_en;
                if (inflight) begin
                    skid_q[tail] <= bus.fifo_data;
                    tail         <= wrap_inc(tail);
                end
                if (handshake) begin
                    head <= wrap_inc(head);
                end
                cnt <= cnt_nxt[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush) begin
            assert (cnt_nxt <= 3'd3);
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = (cnt != 2'd0);
    assign bus.m_data     = skid_q[head];
    assign bus.words_out  = words_q;
    assign bus.busy       = (cnt != 2'd0) || inflight;
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a behavioural FIFO feeds the main instance,
// and a second instance with a 4-bit counter exercises words_out wrap.
module tb_fifo_stream_reader;
    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
    fifo_stream_reader_if #(.DATA_WIDTH(8), .CNT_WIDTH(4))  bus2 ();

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_wrap (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    logic [7:0] mem [64];
    int wp = 0;
    int rp = 0;
    assign bus.fifo_empty = (wp == rp);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= mem[rp[5:0]];
            rp <= rp + 1;
        end
    end

    int pushed2 = 0;
    int popped2 = 0;
    assign bus2.fifo_empty = (pushed2 == popped2);
    always @(posedge clk) begin
        if (bus2.fifo_rd_en) begin
            bus2.fifo_data <= 8'(popped2 + 1);
            popped2 <= popped2 + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int pops;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wp[5:0]] = d;
        wp = wp + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        rst2 = 1'b0;
        bus.flush = 1'b0;
        bus.m_ready = 1'b0;
        bus2.flush = 1'b0;
        bus2.m_ready = 1'b0;
        #1;
        rst = 1'b1;
        rst2 = 1'b1;
        for (int i = 0; i < 8; i++) push(8'(16 + i));

        // Reset held with words waiting in the FIFO
        tick();
        tick();
        check("reset rd_en", bus.fifo_rd_en, 0);
        check("reset m_valid", bus.m_valid, 0);
        check("reset m_data", bus.m_data, 0);
        check("reset words_out", bus.words_out, 0);
        check("reset busy", bus.busy, 0);

        // Streaming 0x10..0x17
        rst = 1'b0;
        bus.m_ready = 1'b1;
        #1;
        check("first pop after reset", bus.fifo_rd_en, 1);
        tick();
        check("latency c+1 m_valid", bus.m_valid, 0);
        check("latency c+1 busy", bus.busy, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            check("stream m_valid", bus.m_valid, 1);
            check("stream m_data", bus.m_data, 32'(16 + i));
            tick();
        end
        check("stream words_out", bus.words_out, 8);
        check("stream drained m_valid", bus.m_valid, 0);
        check("stream drained busy", bus.busy, 0);

        // Backpressure: 6 words queued, consumer stalled
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(16 + i));
        #1;
        pops = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.fifo_rd_en) pops++;
            tick();
        end
        check("backpressure pop count", pops, 3);
        check("backpressure rd_en", bus.fifo_rd_en, 0);
        check("backpressure m_valid", bus.m_valid, 1);
        check("backpressure m_data hold", bus.m_data, 8'h10);
        check("backpressure words_out", bus.words_out, 8);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("release m_valid", bus.m_valid, 1);
            check("release m_data", bus.m_data, 32'(16 + i));
            tick();
        end
        check("release words_out", bus.words_out, 14);
        check("release drained m_valid", bus.m_valid, 0);
        check("release drained busy", bus.busy, 0);

        // Sparse FIFO: one 0xA5 every 3 cycles
        for (int k = 0; k < 4; k++) begin
            push(8'hA5);
            #1;
            check("sparse pop", bus.fifo_rd_en, 1);
            tick();
            check("sparse no pop on empty", bus.fifo_rd_en & bus.fifo_empty, 0);
            check("sparse rd_en idle", bus.fifo_rd_en, 0);
            check("sparse inflight busy", bus.busy, 1);
            check("sparse not yet valid", bus.m_valid, 0);
            tick();
            check("sparse m_valid", bus.m_valid, 1);
            check("sparse m_data", bus.m_data, 8'hA5);
            check("sparse rd_en idle 2", bus.fifo_rd_en, 0);
            tick();
            check("sparse single delivery", bus.m_valid, 0);
            check("sparse busy drops", bus.busy, 0);
        end
        check("sparse words_out", bus.words_out, 18);

        // Flush with the buffer full (2 held + 1 in flight is the reservation limit)
        bus.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
        #1;
        check("flush fill pop 1", bus.fifo_rd_en, 1);
        tick();
        check("flush fill pop 2", bus.fifo_rd_en, 1);
        tick();
        check("flush fill pop 3", bus.fifo_rd_en, 1);
        tick();
        check("flush full no pop", bus.fifo_rd_en, 0);
        check("flush pre m_data", bus.m_data, 8'h30);
        bus.flush = 1'b1;
        #1;
        check("flush blocks rd_en", bus.fifo_rd_en, 0);
        tick();
        bus.flush = 1'b0;
        check("flush clears m_valid", bus.m_valid, 0);
        check("flush clears busy", bus.busy, 0);
        #1;
        check("resume after flush", bus.fifo_rd_en, 1);
        bus.m_ready = 1'b1;
        tick();
        check("post flush c+1 m_valid", bus.m_valid, 0);
        tick();
        check("post flush m_valid", bus.m_valid, 1);
        check("post flush next entry", bus.m_data, 8'h33);
        tick();
        check("post flush second", bus.m_data, 8'h34);
        tick();
        check("post flush drained", bus.m_valid, 0);
        check("post flush words_out", bus.words_out, 20);

        // Asynchronous reset mid-stream
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(8'(8'h40 + i));
        tick();
        tick();
        check("midstream m_valid", bus.m_valid, 1);
        rst = 1'b1;
        #1;
        check("async reset m_valid", bus.m_valid, 0);
        check("async reset busy", bus.busy, 0);
        check("async reset rd_en", bus.fifo_rd_en, 0);
        check("async reset words_out", bus.words_out, 0);
        check("async reset m_data", bus.m_data, 0);

        // Counter wrap on the 4-bit instance: 17 words
        tick();
        rst2 = 1'b0;
        bus2.m_ready = 1'b1;
        pushed2 = 17;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 17) check("wrap words_out 15", bus2.words_out, 4'hF);
            if (k == 18) check("wrap words_out 16", bus2.words_out, 4'h0);
            if (k == 19) check("wrap words_out 17", bus2.words_out, 4'h1);
        end
        check("wrap drained", bus2.m_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
